// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter.
//   - default geometry / widths for a 640x480 RGB888 frame buffer
//   - pixel_t       : one frame-buffer word
//   - arb_state_e   : arbiter phase (IDLE / FETCH / DRAIN)
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_W    = 24;
  localparam int ADDR_W   = 19;
  localparam int MEM_LAT  = 1;
  localparam int WR_EVERY = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tag pipeline: carries {valid, column} alongside an outstanding
// frame-buffer read so the return can be steered into the line buffer.
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : synchronous clear of every valid (row abort)
//   vld_i, x_i  : tag of the read issued this cycle
//   vld_o, x_o  : tag aligned with the read data arriving this cycle
module fb_rd_pipe #(
  parameter int LAT = 1,
  parameter int XW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          vld_i,
  input  logic [XW-1:0] x_i,
  output logic          vld_o,
  output logic [XW-1:0] x_o
);

  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][XW-1:0] x_pipe;

  // Flush also drops the tag entering this cycle, so a read issued in the
  // abort cycle never lands in the line buffer.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_i;
      for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Tags need no reset; they are qualified by vld_pipe.
  always_ff @(posedge clk) begin
    x_pipe[0] <= x_i;
    for (int i = 1; i < LAT; i++) x_pipe[i] <= x_pipe[i-1];
  end

  assign vld_o = vld_pipe[LAT-1];
  assign x_o   = x_pipe[LAT-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter between the VGA line prefetcher and the
// pixel writer. On each line start a visible row is read into one bank of a
// ping-pong line buffer; writes use idle cycles plus a guaranteed slot after
// every WR_EVERY-1 consecutive fetch reads.
//   clk, rst                 : clock, synchronous active-high reset
//   i_line_start/i_fetch_row : start prefetch of a row (ignored if off-screen)
//   i_wr_* / o_wr_ready      : writer valid/ready port (x, y, pixel)
//   o_mem_* / i_mem_rdata    : frame-buffer port, read data MEM_LAT later
//   o_lb_*                   : line-buffer write port, o_lb_bank = bank filled
//   o_fetch_done             : pulse with the last pixel of the row
//   o_underrun/i_clr_underrun: sticky "line start before fetch finished"
module vga_fb_arbiter #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int PIX_W    = vga_pkg::PIX_W,
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int MEM_LAT  = vga_pkg::MEM_LAT,
  parameter int WR_EVERY = vga_pkg::WR_EVERY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_start,
  input  logic [8:0]        i_fetch_row,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [9:0]        i_wr_x,
  input  logic [8:0]        i_wr_y,
  input  logic [PIX_W-1:0]  i_wr_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [PIX_W-1:0]  o_mem_wdata,
  input  logic [PIX_W-1:0]  i_mem_rdata,
  output logic              o_lb_we,
  output logic [9:0]        o_lb_addr,
  output logic [PIX_W-1:0]  o_lb_data,
  output logic              o_lb_bank,
  output logic              o_fetch_done,
  output logic              o_underrun,
  input  logic              i_clr_underrun
);

  import vga_pkg::*;

  localparam int         CNT_W = $clog2(WR_EVERY);
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WR_EVERY - 1);

  arb_state_e         state_q;
  logic [8:0]         row_q;
  logic [9:0]         x_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bank_q, underrun_q, lb_we_q, done_q;
  logic [9:0]         lb_addr_q;
  logic [PIX_W-1:0]   lb_data_q;

  logic in_fetch, slot_ok, wr_ready, wr_xfer, wr_in_range, rd_issue, abort;
  logic ret_vld, last_ret;
  logic [9:0] ret_x;

  // Row base: 640 = 512 + 128, so a shift-add avoids a multiplier.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] r, input logic [9:0] c);
    logic [ADDR_W-1:0] base;
    if (H_ACTIVE == 640) base = (ADDR_W'(r) << 9) + (ADDR_W'(r) << 7);
    else                 base = ADDR_W'(r) * ADDR_W'(H_ACTIVE);
    return base + ADDR_W'(c);
  endfunction

  assign in_fetch    = (state_q == FETCH);
  assign slot_ok     = (cnt_q == CNT_SAT);
  // Ready never depends on valid; in FETCH it opens only once the read run
  // has saturated, otherwise the port is free for the writer.
  assign wr_ready    = !rst && (!in_fetch || slot_ok);
  assign wr_xfer     = i_wr_valid && wr_ready;
  assign wr_in_range = (i_wr_x < H_LIM) && (i_wr_y < V_LIM);
  assign rd_issue    = in_fetch && !wr_xfer;
  assign abort       = i_line_start && (state_q != IDLE);

  assign o_wr_ready  = wr_ready;
  assign o_mem_we    = wr_xfer && wr_in_range;
  assign o_mem_addr  = wr_xfer ? pix_addr(i_wr_y, i_wr_x) : pix_addr(row_q, x_q);
  assign o_mem_wdata = i_wr_data;

  fb_rd_pipe #(.LAT(MEM_LAT), .XW(10)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .vld_i   (rd_issue),
    .x_i     (x_q),
    .vld_o   (ret_vld),
    .x_o     (ret_x)
  );

  assign last_ret = ret_vld && (ret_x == H_LIM - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      x_q        <= '0;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      underrun_q <= 1'b0;
      lb_we_q    <= 1'b0;
      done_q     <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      lb_we_q <= 1'b0;
      done_q  <= 1'b0;
      // Returns belonging to an aborted row would land in the new bank.
      if (ret_vld && !abort) begin
        lb_we_q   <= 1'b1;
        lb_addr_q <= ret_x;
        lb_data_q <= i_mem_rdata;
        done_q    <= last_ret;
      end

      if (abort)               underrun_q <= 1'b1;
      else if (i_clr_underrun) underrun_q <= 1'b0;

      if (i_line_start) begin
        if (i_fetch_row < V_LIM) begin
          state_q <= FETCH;
          bank_q  <= ~bank_q;
          row_q   <= i_fetch_row;
          x_q     <= '0;
          cnt_q   <= '0;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        unique case (state_q)
          FETCH: begin
            if (wr_xfer) begin
              cnt_q <= '0;
            end else begin
              x_q <= x_q + 10'd1;
              if (!slot_ok) cnt_q <= cnt_q + CNT_W'(1);
              if (x_q == H_LIM - 10'd1) state_q <= DRAIN;
            end
          end
          DRAIN:   if (last_ret) state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign o_lb_we      = lb_we_q;
  assign o_lb_addr    = lb_addr_q;
  assign o_lb_data    = lb_data_q;
  assign o_lb_bank    = bank_q;
  assign o_fetch_done = done_q;
  assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int PW = 24;
  localparam int AW = 19;
  localparam int ML = 1;
  localparam int WE = 4;

  logic          clk = 0;
  logic          rst, line_start, wr_valid, wr_ready, mem_we, lb_we;
  logic          lb_bank, fetch_done, underrun, clr_underrun;
  logic [8:0]    fetch_row, wr_y;
  logic [9:0]    wr_x, lb_addr;
  logic [PW-1:0] wr_data, mem_wdata, mem_rdata, lb_data;
  logic [AW-1:0] mem_addr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .ADDR_W(AW),
                   .MEM_LAT(ML), .WR_EVERY(WE)) dut (
    .clk(clk), .rst(rst), .i_line_start(line_start), .i_fetch_row(fetch_row),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_x(wr_x), .i_wr_y(wr_y),
    .i_wr_data(wr_data), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_lb_we(lb_we),
    .o_lb_addr(lb_addr), .o_lb_data(lb_data), .o_lb_bank(lb_bank),
    .o_fetch_done(fetch_done), .o_underrun(underrun), .i_clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer whose contents equal the address, one cycle of latency.
  always @(posedge clk) mem_rdata <= PW'(mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; int x; int a; } ret_t;
  ret_t q[$];
  int   ph = 0;          // 0 idle, 1 fetching, 2 draining
  int   m_row = 0, nx = 0, run = 0;
  bit   e_we = 0, e_done = 0, e_bank = 0, e_und = 0;
  int   e_addr = 0, e_data = 0;

  always @(negedge clk) begin : model
    bit rdy, xfer, wok, rd;
    int ph0;
    ret_t r;
    if (cyc > 0) begin
      rdy  = !rst && (ph != 1 || run >= WE - 1);
      xfer = wr_valid && rdy;
      wok  = xfer && wr_x < H && wr_y < V;
      rd   = !rst && ph == 1 && !xfer;
      chk("ready", wr_ready, rdy);
      chk("mem_we", mem_we, wok);
      if (wok) begin
        chk("wr_addr", mem_addr, wr_y * H + wr_x);
        chk("wr_data", mem_wdata, wr_data);
      end
      if (rd) chk("rd_addr", mem_addr, m_row * H + nx);
      chk("lb_we", lb_we, e_we);
      if (e_we) begin
        chk("lb_addr", lb_addr, e_addr);
        chk("lb_data", lb_data, e_data);
      end
      chk("fetch_done", fetch_done, e_done);
      chk("bank", lb_bank, e_bank);
      chk("underrun", underrun, e_und);

      e_we = 0; e_done = 0;
      if (rst) begin
        q.delete(); ph = 0; e_bank = 0; e_und = 0; e_addr = 0; e_data = 0;
      end else if (line_start) begin
        if (ph != 0) begin e_und = 1; q.delete(); end
        else if (clr_underrun) e_und = 0;
        if (fetch_row < V) begin
          ph = 1; e_bank = !e_bank; m_row = fetch_row; nx = 0; run = 0;
        end else ph = 0;
      end else begin
        if (clr_underrun) e_und = 0;
        ph0 = ph;
        if (q.size() > 0 && q[0].due == cyc) begin
          r = q.pop_front();
          e_we = 1; e_addr = r.x; e_data = r.a; e_done = (r.x == H - 1);
          if (r.x == H - 1) ph = 0;
        end
        if (ph0 == 1) begin
          if (xfer) run = 0;
          else begin
            r.due = cyc + ML; r.x = nx; r.a = m_row * H + nx;
            q.push_back(r);
            if (nx == H - 1) ph = 2;
            nx++;
            if (run < WE - 1) run++;
          end
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int lb_cnt, first_a, first_d, last_d, grants, dt, L, bad;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Watches until fetch_done (bounded); records line-buffer traffic and the
  // writer grants landing in the FETCH window of a wr_valid-held row.
  task automatic wait_done(input int start);
    lb_cnt = 0; grants = 0; first_a = -1; first_d = -1; last_d = -1; dt = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (wr_valid && wr_ready && cyc > start && cyc <= start + 21) grants++;
      if (lb_we) begin
        if (lb_cnt == 0) begin first_a = lb_addr; first_d = lb_data; end
        last_d = lb_data; lb_cnt++;
      end
      if (fetch_done) begin dt = cyc - start; return; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1; line_start = 0; fetch_row = 0; wr_valid = 0; wr_x = 0; wr_y = 0;
    wr_data = 0; clr_underrun = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_bank", lb_bank, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_lb_we", lb_we, 0);
    chk("rst_ready", wr_ready, 1);

    // Plain fetch of row 2
    tick(); line_start = 1; fetch_row = 2; L = cyc;
    tick(); line_start = 0;
    wait_done(L);
    chk("t1_latency", dt, 18);
    chk("t1_lb_cnt", lb_cnt, 16);
    chk("t1_first_addr", first_a, 0);
    chk("t1_first_data", first_d, 32);
    chk("t1_last_data", last_d, 47);
    chk("t1_bank", lb_bank, 1);

    // Fetch with writer always requesting
    tick(); line_start = 1; fetch_row = 2; L = cyc;
    wr_valid = 1; wr_x = 5; wr_y = 3; wr_data = 24'h123456;
    tick(); line_start = 0;
    wait_done(L);
    chk("t2_latency", dt, 23);
    chk("t2_grants", grants, 5);
    chk("t2_lb_cnt", lb_cnt, 16);
    chk("t2_last_data", last_d, 47);
    chk("t2_bank", lb_bank, 0);

    // Idle writes: in range, then off-screen
    tick(); wr_valid = 1; wr_x = 3; wr_y = 1; wr_data = 24'hABCDEF;
    @(negedge clk);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 19);
    chk("t3_wdata", mem_wdata, 24'hABCDEF);
    tick(); wr_x = 16; wr_y = 0;
    @(negedge clk);
    chk("t4_ready", wr_ready, 1);
    chk("t4_we", mem_we, 0);
    tick(); wr_valid = 0;

    // Underrun: new line start 10 cycles into a fetch
    tick(); line_start = 1; fetch_row = 1; L = cyc;
    tick(); line_start = 0;
    repeat (9) tick();
    line_start = 1; fetch_row = 3; L = cyc;
    tick(); line_start = 0;
    @(negedge clk);
    chk("t5_underrun", underrun, 1);
    chk("t5_no_stale", lb_we, 0);
    chk("t5_bank", lb_bank, 0);
    tick();
    wait_done(L);
    chk("t5_latency", dt, 18);
    chk("t5_first_addr", first_a, 0);
    chk("t5_first_data", first_d, 48);
    chk("t5_sticky", underrun, 1);
    tick(); clr_underrun = 1;
    tick(); clr_underrun = 0;
    @(negedge clk);
    chk("t5_cleared", underrun, 0);

    // Reset mid-fetch, then an off-screen line start
    tick(); line_start = 1; fetch_row = 0;
    tick(); line_start = 0;
    repeat (4) tick();
    rst = 1;
    tick(); rst = 0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (lb_we || fetch_done || lb_bank || underrun) bad++;
      tick();
    end
    chk("t6_after_rst", bad, 0);
    line_start = 1; fetch_row = 5;
    tick(); line_start = 0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (lb_we || fetch_done || lb_bank) bad++;
      tick();
    end
    chk("t6_offscreen", bad, 0);

    // Randomised traffic, checked cycle by cycle by the model
    for (int k = 0; k < 4000; k++) begin
      rst          = ($urandom_range(0, 599) == 0);
      line_start   = ($urandom_range(0, 39) == 0);
      fetch_row    = 9'($urandom_range(0, 5));
      wr_valid     = ($urandom_range(0, 2) != 0);
      wr_x         = 10'($urandom_range(0, 17));
      wr_y         = 9'($urandom_range(0, 4));
      wr_data      = PW'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 0; line_start = 0; wr_valid = 0; clr_underrun = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
